fp_add_seq: RTL and testbench

FP_ADD_SEQ -- requirements
Module: fp_add_seq

---
 rtl/fp_pkg.sv | 23 ++
 rtl/fp_norm.sv | 50 +++++
 rtl/fp_add_seq.sv | 161 ++++++++++++++++
 tb/tb_fp_add_seq.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// Shared 13-bit float format: widths, field offsets and the adder FSM encoding.
// Used by the adder top, its normalize stage and the converter stages.
package fp_pkg;

  localparam int EXP_W    = 4;
  localparam int FRAC_W   = 8;
  localparam int FP_W     = 13;

  localparam int FRAC_LSB = 0;
  localparam int FRAC_MSB = FRAC_W - 1;
  localparam int EXP_LSB  = FRAC_W;
  localparam int EXP_MSB  = FRAC_W + EXP_W - 1;
  localparam int SIGN_POS = FP_W - 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ALIGN,
    S_ADD,
    S_NORM,
    S_DONE
  } fsm_state_t;

endpackage

// File: rtl/fp_norm.sv
// Single normalize step for the adder result: carry, zero, normalized or shift-left.
// Purely combinational; the caller iterates once per cycle until o_done is set.
module fp_norm #(
  parameter int EXP_W  = 4,
  parameter int FRAC_W = 8
) (
  input  logic [FRAC_W:0]   i_frac,
  input  logic [EXP_W-1:0]  i_exp,
  input  logic              i_sign,
  output logic [FRAC_W:0]   o_frac,
  output logic [EXP_W-1:0]  o_exp,
  output logic              o_sign,
  output logic              o_done,
  output logic              o_ovf
);
  import fp_pkg::*;

  always_comb begin
    o_frac = i_frac;
    o_exp  = i_exp;
    o_sign = i_sign;
    o_done = 1'b0;
    o_ovf  = 1'b0;
    if (i_frac[FRAC_W]) begin
      // A carry at the top exponent saturates to the largest magnitude.
      if (i_exp == '1) begin
        o_frac = {1'b0, {FRAC_W{1'b1}}};
        o_done = 1'b1;
        o_ovf  = 1'b1;
      end else begin
        o_frac = i_frac >> 1;
        o_exp  = i_exp + 1'b1;
      end
    end else if (i_frac == '0) begin
      o_sign = 1'b0;
      o_exp  = '0;
      o_done = 1'b1;
    end else if (i_frac[FRAC_W-1]) begin
      o_done = 1'b1;
    end else if (i_exp == '0) begin
      o_frac = '0;
      o_sign = 1'b0;
      o_done = 1'b1;
    end else begin
      o_frac = i_frac << 1;
      o_exp  = i_exp - 1'b1;
    end
  end

endmodule

// File: rtl/fp_add_seq.sv
// Sequential 13-bit float adder, truncating and saturating; latency 4 + align distance + normalize shifts.
// ready is low while busy and start is ignored then; FP_ADD_SUB_EN adds a sub port (a - b).
module fp_add_seq #(
  parameter int EXP_W  = fp_pkg::EXP_W,
  parameter int FRAC_W = fp_pkg::FRAC_W
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    start,
`ifdef FP_ADD_SUB_EN
  input  logic                    sub,
`endif
  input  logic [fp_pkg::FP_W-1:0] a,
  input  logic [fp_pkg::FP_W-1:0] b,
  output logic                    ready,
  output logic                    done_tick,
  output logic [fp_pkg::FP_W-1:0] sum,
  output logic                    ovf
);
  import fp_pkg::*;

  localparam int DIFF_W = $clog2(FRAC_W + 1);

  fsm_state_t        r_state;
  fsm_state_t        w_state_nxt;

  logic              w_b_sign;
  logic              w_a_big;
  logic [EXP_W-1:0]  w_exp_big;
  logic [EXP_W-1:0]  w_exp_small;
  logic [EXP_W-1:0]  w_diff_full;
  logic [DIFF_W-1:0] w_diff_load;

  logic              r_sign_big;
  logic              r_sign_small;
  logic [EXP_W-1:0]  r_exp;
  logic [FRAC_W-1:0] r_frac_big;
  logic [FRAC_W-1:0] r_frac_small;
  logic [DIFF_W-1:0] r_diff;
  logic [FRAC_W:0]   r_res_frac;
  logic              r_res_sign;
  logic              r_res_ovf;
  logic [FP_W-1:0]   r_sum;
  logic              r_ovf;
  logic              r_done_tick;

  logic [FRAC_W:0]   w_norm_frac;
  logic [EXP_W-1:0]  w_norm_exp;
  logic              w_norm_sign;
  logic              w_norm_done;
  logic              w_norm_ovf;

  // Operand ordering at capture; a wins a magnitude tie.
  always_comb begin
    w_b_sign = b[SIGN_POS];
`ifdef FP_ADD_SUB_EN
    w_b_sign = b[SIGN_POS] ^ sub;
`endif
    w_a_big     = a[EXP_MSB:FRAC_LSB] >= b[EXP_MSB:FRAC_LSB];
    w_exp_big   = w_a_big ? a[EXP_MSB:EXP_LSB] : b[EXP_MSB:EXP_LSB];
    w_exp_small = w_a_big ? b[EXP_MSB:EXP_LSB] : a[EXP_MSB:EXP_LSB];
    w_diff_full = w_exp_big - w_exp_small;
    w_diff_load = (w_diff_full > EXP_W'(FRAC_W)) ? DIFF_W'(FRAC_W) : DIFF_W'(w_diff_full);
  end

  fp_norm #(
    .EXP_W  (EXP_W),
    .FRAC_W (FRAC_W)
  ) u_norm (
    .i_frac (r_res_frac),
    .i_exp  (r_exp),
    .i_sign (r_res_sign),
    .o_frac (w_norm_frac),
    .o_exp  (w_norm_exp),
    .o_sign (w_norm_sign),
    .o_done (w_norm_done),
    .o_ovf  (w_norm_ovf)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_nxt = S_ALIGN;
      S_ALIGN: if (r_diff == '0) w_state_nxt = S_ADD;
      S_ADD:   w_state_nxt = S_NORM;
      S_NORM:  if (w_norm_done) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sign_big   <= 1'b0;
      r_sign_small <= 1'b0;
      r_exp        <= '0;
      r_frac_big   <= '0;
      r_frac_small <= '0;
      r_diff       <= '0;
      r_res_frac   <= '0;
      r_res_sign   <= 1'b0;
      r_res_ovf    <= 1'b0;
      r_sum        <= '0;
      r_ovf        <= 1'b0;
      r_done_tick  <= 1'b0;
    end else begin
      r_done_tick <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_sign_big   <= w_a_big ? a[SIGN_POS] : w_b_sign;
            r_sign_small <= w_a_big ? w_b_sign : a[SIGN_POS];
            r_frac_big   <= w_a_big ? a[FRAC_MSB:FRAC_LSB] : b[FRAC_MSB:FRAC_LSB];
            r_frac_small <= w_a_big ? b[FRAC_MSB:FRAC_LSB] : a[FRAC_MSB:FRAC_LSB];
            r_exp        <= w_exp_big;
            r_diff       <= w_diff_load;
            r_res_ovf    <= 1'b0;
          end
        end
        S_ALIGN: begin
          if (r_diff != '0) begin
            r_frac_small <= r_frac_small >> 1;
            r_diff       <= r_diff - 1'b1;
          end
        end
        S_ADD: begin
          r_res_frac <= (r_sign_big == r_sign_small) ?
                        ({1'b0, r_frac_big} + {1'b0, r_frac_small}) :
                        ({1'b0, r_frac_big} - {1'b0, r_frac_small});
          r_res_sign <= r_sign_big;
        end
        S_NORM: begin
          r_res_frac <= w_norm_frac;
          r_exp      <= w_norm_exp;
          r_res_sign <= w_norm_sign;
          r_res_ovf  <= w_norm_ovf;
        end
        S_DONE: begin
          r_sum       <= {r_res_sign, r_exp, r_res_frac[FRAC_W-1:0]};
          r_ovf       <= r_res_ovf;
          r_done_tick <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign ready     = (r_state == S_IDLE);
  assign done_tick = r_done_tick;
  assign sum       = r_sum;
  assign ovf       = r_ovf;

endmodule

// File: tb/tb_fp_add_seq.sv
// Directed bench for fp_add_seq: arithmetic reference model, per-cycle output monitor, literal pins.
module tb_fp_add_seq;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [12:0] a;
  logic [12:0] b;
`ifdef FP_ADD_SUB_EN
  logic        sub_i;
`endif
  logic        ready;
  logic        done_tick;
  logic [12:0] sum;
  logic        ovf;

  typedef struct {
    logic [12:0] sum;
    logic        ovf;
    int          due;
  } exp_t;

  typedef struct {
    logic [12:0] x;
    logic [12:0] y;
    logic        s;
    logic [12:0] r;
    logic        o;
    int          lat;
  } vec_t;

  exp_t        q[$];
  exp_t        mon_e;
  vec_t        vq[$];
  int          n_checks = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          n_done = 0;
  int          n_pushed = 0;
  int          n_flushed = 0;
  logic [12:0] hold_sum = '0;
  logic        hold_ovf = 1'b0;
  bit          mon_en = 1'b0;

  fp_add_seq dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
`ifdef FP_ADD_SUB_EN
    .sub       (sub_i),
`endif
    .a         (a),
    .b         (b),
    .ready     (ready),
    .done_tick (done_tick),
    .sum       (sum),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: actual %0h expected %0h (t=%0t)", nm, act, expv, $time);
    end
  endtask

  // Value = (-1)^s * frac/256 * 2^exp, evaluated with integer magnitudes.
  function automatic logic [13:0] model(input logic [12:0] x, input logic [12:0] y_in,
                                        input logic s, output int lat);
    logic [12:0] y, bg, sm;
    int d, m, e, steps;
    logic sg;
    y = y_in;
    if (s) y[12] = ~y[12];
    if (x[11:0] >= y[11:0]) begin bg = x; sm = y; end
    else begin bg = y; sm = x; end
    d = int'(bg[11:8]) - int'(sm[11:8]);
    if (d > 8) d = 8;
    if (bg[12] == sm[12]) m = int'(bg[7:0]) + (int'(sm[7:0]) >> d);
    else                  m = int'(bg[7:0]) - (int'(sm[7:0]) >> d);
    e = int'(bg[11:8]);
    sg = bg[12];
    steps = 0;
    lat = d + 4;
    if (m >= 256) begin
      if (e == 15) return {1'b1, sg, 4'hF, 8'hFF};
      m = m / 2;
      e = e + 1;
      steps = 1;
    end else if (m == 0) begin
      return 14'h0;
    end else begin
      while (m < 128) begin
        if (e == 0) begin
          lat = d + 4 + steps;
          return 14'h0;
        end
        m = m * 2;
        e = e - 1;
        steps++;
      end
    end
    lat = d + 4 + steps;
    return {1'b0, sg, 4'(e), 8'(m)};
  endfunction

  // Compare process: every done_tick is matched to the oldest expectation; otherwise outputs must hold.
  always @(negedge clk) begin
    if (!reset_n) begin
      n_flushed += q.size();
      q.delete();
      hold_sum = '0;
      hold_ovf = 1'b0;
    end else if (mon_en) begin
      if (done_tick) begin
        n_done++;
        if (q.size() == 0) begin
          chk("unexpected_done_tick", 32'(done_tick), 32'(0));
        end else begin
          mon_e = q.pop_front();
          chk("sum", 32'(sum), 32'(mon_e.sum));
          chk("ovf", 32'(ovf), 32'(mon_e.ovf));
          chk("done_latency", cyc, mon_e.due);
          hold_sum = mon_e.sum;
          hold_ovf = mon_e.ovf;
        end
      end else begin
        chk("sum_hold", 32'(sum), 32'(hold_sum));
        chk("ovf_hold", 32'(ovf), 32'(hold_ovf));
      end
    end
  end

  task automatic run_op(input logic [12:0] x, input logic [12:0] y, input logic s);
    int lat;
    logic [13:0] r;
    @(negedge clk);
    for (int i = 0; i < 50 && !ready; i++) @(negedge clk);
    chk("ready_before_start", 32'(ready), 32'(1));
    r = model(x, y, s, lat);
    a = x;
    b = y;
`ifdef FP_ADD_SUB_EN
    sub_i = s;
`endif
    start = 1'b1;
    q.push_back('{sum: r[12:0], ovf: r[13], due: cyc + 1 + lat});
    n_pushed++;
    @(negedge clk);
    start = 1'b0;
    a = 13'($urandom);
    b = 13'($urandom);
  endtask

  task automatic wait_done();
    for (int i = 0; i < 100 && q.size() != 0; i++) @(posedge clk);
    chk("done_timeout", 32'(q.size()), 32'(0));
    if (q.size() != 0) begin
      n_flushed += q.size();
      q.delete();
    end
    #1;
  endtask

  initial begin
    int lat;
    logic [13:0] r;
    vq.push_back('{13'h0180, 13'h0180, 1'b0, 13'h0280, 1'b0, 5});   // 1 + 1
    vq.push_back('{13'h02C0, 13'h12C0, 1'b0, 13'h0000, 1'b0, 4});   // 3 - 3
    vq.push_back('{13'h0780, 13'h0180, 1'b0, 13'h0782, 1'b0, 10});  // 64 + 1
    vq.push_back('{13'h0F80, 13'h0F80, 1'b0, 13'h0FFF, 1'b1, 4});   // overflow
    vq.push_back('{13'h0480, 13'h13E0, 1'b0, 13'h0180, 1'b0, 8});   // 8 - 7
    vq.push_back('{13'h13E0, 13'h0000, 1'b0, 13'h13E0, 1'b0, 7});   // x + 0
    vq.push_back('{13'h0000, 13'h0480, 1'b0, 13'h0480, 1'b0, 8});   // 0 + x
    vq.push_back('{13'h00C0, 13'h1080, 1'b0, 13'h0000, 1'b0, 4});   // underflow at once
    vq.push_back('{13'h01C0, 13'h11A0, 1'b0, 13'h0000, 1'b0, 5});   // underflow after a shift
    vq.push_back('{13'h0F80, 13'h0180, 1'b0, 13'h0F80, 1'b0, 12});  // diff saturates at 8
    vq.push_back('{13'h00C0, 13'h00C0, 1'b0, 13'h01C0, 1'b0, 5});   // carry, no overflow
    vq.push_back('{13'h0180, 13'h00FF, 1'b0, 13'h01FF, 1'b0, 5});   // align truncation
    vq.push_back('{13'h0281, 13'h0280, 1'b0, 13'h0380, 1'b0, 5});   // carry truncation
    vq.push_back('{13'h12C0, 13'h02C0, 1'b0, 13'h0000, 1'b0, 4});   // tie, a negative
`ifdef FP_ADD_SUB_EN
    vq.push_back('{13'h02C0, 13'h02C0, 1'b1, 13'h0000, 1'b0, 4});   // 3 - 3 via sub
    vq.push_back('{13'h0180, 13'h1180, 1'b1, 13'h0280, 1'b0, 5});   // 1 - (-1)
    sub_i = 1'b0;
`endif

    reset_n = 1'b0;
    start = 1'b0;
    a = '0;
    b = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_ready", 32'(ready), 32'(1));
    chk("reset_done_tick", 32'(done_tick), 32'(0));
    chk("reset_sum", 32'(sum), 32'(0));
    chk("reset_ovf", 32'(ovf), 32'(0));
    reset_n = 1'b1;
    mon_en = 1'b1;

    foreach (vq[i]) begin
      r = model(vq[i].x, vq[i].y, vq[i].s, lat);
      chk($sformatf("model_sum_%0d", i), 32'(r[12:0]), 32'(vq[i].r));
      chk($sformatf("model_ovf_%0d", i), 32'(r[13]), 32'(vq[i].o));
      chk($sformatf("model_lat_%0d", i), lat, vq[i].lat);
      run_op(vq[i].x, vq[i].y, vq[i].s);
      wait_done();
      chk($sformatf("dut_sum_%0d", i), 32'(sum), 32'(vq[i].r));
      chk($sformatf("dut_ovf_%0d", i), 32'(ovf), 32'(vq[i].o));
    end

    // Starts while busy must be dropped.
    run_op(13'h0480, 13'h13E0, 1'b0);
    for (int k = 0; k < 2; k++) begin
      a = 13'h0F80;
      b = 13'h0F80;
      start = 1'b1;
      chk("busy_ready", 32'(ready), 32'(0));
      @(negedge clk);
    end
    start = 1'b0;
    wait_done();
    chk("busy_sum", 32'(sum), 32'(13'h0180));
    chk("busy_ovf", 32'(ovf), 32'(0));

    // Reset in the middle of ALIGN aborts the operation.
    run_op(13'h0F80, 13'h0180, 1'b0);
    repeat (2) @(negedge clk);
    chk("align_not_ready", 32'(ready), 32'(0));
    #2 reset_n = 1'b0;
    #1;
    chk("abort_ready", 32'(ready), 32'(1));
    chk("abort_done_tick", 32'(done_tick), 32'(0));
    chk("abort_sum", 32'(sum), 32'(0));
    chk("abort_ovf", 32'(ovf), 32'(0));
    repeat (2) @(negedge clk);
    #2 reset_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("post_abort_ready", 32'(ready), 32'(1));
    run_op(13'h0180, 13'h0180, 1'b0);
    wait_done();
    chk("post_abort_sum", 32'(sum), 32'(13'h0280));

    repeat (3) @(negedge clk);
    chk("done_count", n_done, n_pushed - n_flushed);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish (t=%0t)", $time);
    $fatal(1, "global timeout");
  end

endmodule
